qcl_breath_sched: RTL

Sequencer that shares one prescaled tick between `els_p` breath-style toggle channels. It walks the enabled channels in ascending index order and runs one channel at a time. The active channel toggles its output every `half_period_i` ticks for `reps_i` full on/off cycles, then control moves to the next enabled channel. It sits between a host/config interface and the status LEDs or other indicator outputs. It replaces per-channel free-running breath counters with one controlled, observable schedule.

---
 rtl/qcl_breath_sched_pkg.sv | 32 +++
 rtl/qcl_breath_prescaler.sv | 29 ++
 rtl/qcl_breath_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/qcl_breath_sched_pkg.sv
// Shared types and helpers for the breath-style channel sequencer.
package qcl_breath_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Widest channel count the search helper supports; masks are zero-extended to it.
    localparam int MAX_ELS = 64;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } bit_sel_t;

    // Lowest set bit of mask at or above position 'from'.
    function automatic bit_sel_t next_set_bit(input logic [MAX_ELS-1:0] mask, input int from);
        bit_sel_t r;
        r = '0;
        for (int i = MAX_ELS - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                r.found = 1'b1;
                r.idx   = 6'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qcl_breath_prescaler.sv
// Free-running divider producing a one-cycle strobe every prescale_p enabled cycles.
module qcl_breath_prescaler #(
    parameter int prescale_p = 1000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (prescale_p > 1) ? $clog2(prescale_p) : 1;
    localparam logic [CW-1:0] LAST = CW'(prescale_p - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (en_i) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick_o = en_i && (count == LAST);

endmodule

// File: rtl/qcl_breath_sched.sv
// Walks enabled channels in ascending order, toggling one at a time from a shared prescaled tick.
module qcl_breath_sched
    import qcl_breath_sched_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int prescale_p   = 1000,
    parameter int width_p      = 16,
    parameter int reps_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_v_i,
    output logic                          start_ready_o,
    input  logic [width_p-1:0]            half_period_i,
    input  logic [reps_width_p-1:0]       reps_i,
    input  logic [els_p-1:0]              mask_i,
    input  logic                          abort_i,
    output logic                          tick_o,
    output logic [els_p-1:0]              en_o,
    output logic [els_p-1:0]              o,
    output logic [((els_p > 1) ? $clog2(els_p) : 1)-1:0] active_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int AW = (els_p > 1) ? $clog2(els_p) : 1;

    state_t                  state;
    logic [width_p-1:0]      hp_r;
    logic [reps_width_p-1:0] reps_r;
    logic [els_p-1:0]        mask_r;
    logic [width_p-1:0]      tick_cnt;
    logic [reps_width_p-1:0] rep_cnt;
    logic [els_p-1:0]        lvl;
    logic [AW-1:0]           ch;

    logic                    run;
    logic                    tick;
    logic                    handshake;
    logic                    kill;
    logic [width_p-1:0]      hp_eff;
    logic                    half_end;
    logic                    falling;
    logic [width_p-1:0]      tick_inc;
    logic [reps_width_p-1:0] rep_inc;
    logic                    last_rep;
    logic [MAX_ELS-1:0]      mask_in_ext;
    logic [MAX_ELS-1:0]      mask_r_ext;
    bit_sel_t                first_sel;
    bit_sel_t                next_sel;

    assign run       = (state == ST_RUN);
    assign handshake = start_v_i && (state == ST_IDLE);
    assign kill      = abort_i && (run || state == ST_ADVANCE);

    qcl_breath_prescaler #(.prescale_p(prescale_p)) u_prescaler (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (!run),
        .en_i      (run),
        .tick_o    (tick)
    );

    // A zero half-period would never toggle; run it as one tick instead.
    assign hp_eff   = (hp_r == '0) ? width_p'(1) : hp_r;
    assign half_end = tick && (tick_cnt == hp_eff - 1'b1);
    assign falling  = half_end && lvl[ch];
    assign tick_inc = (tick_cnt == '1) ? tick_cnt : tick_cnt + 1'b1;
    assign rep_inc  = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
    assign last_rep = falling && (rep_inc == reps_r);

    always_comb begin
        mask_in_ext = '0;
        mask_r_ext  = '0;
        mask_in_ext[els_p-1:0] = mask_i;
        mask_r_ext[els_p-1:0]  = mask_r;
        first_sel = next_set_bit(mask_in_ext, 0);
        next_sel  = next_set_bit(mask_r_ext, int'(ch) + 1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= ST_IDLE;
            hp_r     <= '0;
            reps_r   <= '0;
            mask_r   <= '0;
            tick_cnt <= '0;
            rep_cnt  <= '0;
            lvl      <= '0;
            ch       <= '0;
        end else if (kill) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            rep_cnt  <= '0;
            lvl      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        hp_r     <= half_period_i;
                        reps_r   <= reps_i;
                        mask_r   <= mask_i;
                        tick_cnt <= '0;
                        rep_cnt  <= '0;
                        if (!first_sel.found || reps_i == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            ch    <= AW'(first_sel.idx);
                        end
                    end
                end
                ST_RUN: begin
                    if (half_end) begin
                        lvl[ch]  <= ~lvl[ch];
                        tick_cnt <= '0;
                        if (falling) rep_cnt <= rep_inc;
                        if (last_rep) state <= ST_ADVANCE;
                    end else if (tick) begin
                        tick_cnt <= tick_inc;
                    end
                end
                ST_ADVANCE: begin
                    tick_cnt <= '0;
                    rep_cnt  <= '0;
                    if (next_sel.found) begin
                        ch    <= AW'(next_sel.idx);
                        state <= ST_RUN;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_o     = '0;
        en_o[ch] = run && tick;
    end

    assign tick_o        = tick;
    assign o             = lvl;
    assign active_o      = ch;
    assign start_ready_o = (state == ST_IDLE);
    assign busy_o        = run || (state == ST_ADVANCE);
    assign done_o        = (state == ST_DONE);

endmodule
